// File: rtl/riscv_pkg.sv
// Shared RISC-V decode constants, NOP encoding, pipeline-control FSM states and
// register-usage helpers used by the hazard and forwarding logic.
package riscv_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_MEM_WAIT  = 2'd1,
        ST_MEM_ABORT = 2'd2
    } pipe_state_e;

    function automatic logic uses_rs1(input logic [6:0] opc);
        return (opc == OPC_R) || (opc == OPC_I) || (opc == OPC_LOAD) ||
               (opc == OPC_STORE) || (opc == OPC_BRANCH) || (opc == OPC_JALR);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opc);
        return (opc == OPC_R) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
    endfunction

    function automatic logic is_mem_op(input logic [6:0] opc);
        return (opc == OPC_LOAD) || (opc == OPC_STORE);
    endfunction

endpackage

// File: rtl/riscv_load_use_det.sv
// Combinational load-use detector: a LOAD in EX whose rd feeds a source
// register that the ID instruction really reads.
module riscv_load_use_det
    import riscv_pkg::*;
(
    input  logic [31:0] inst_s2_i,
    input  logic [31:0] inst_s3_i,
    output logic        load_use_o
);

    logic [4:0] rd_s3;
    logic [4:0] rs1_s2;
    logic [4:0] rs2_s2;
    logic       hit_rs1;
    logic       hit_rs2;
    logic       unused_fields;

    assign rd_s3  = inst_s3_i[11:7];
    assign rs1_s2 = inst_s2_i[19:15];
    assign rs2_s2 = inst_s2_i[24:20];

    assign unused_fields = ^{inst_s3_i[31:12], inst_s2_i[31:25], inst_s2_i[14:7]};

    // Only sources the opcode actually reads count; x0 never creates a hazard.
    assign hit_rs1 = uses_rs1(inst_s2_i[6:0]) && (rs1_s2 == rd_s3);
    assign hit_rs2 = uses_rs2(inst_s2_i[6:0]) && (rs2_s2 == rd_s3);

    always_comb begin
        load_use_o = 1'b0;
        if ((inst_s3_i[6:0] == OPC_LOAD) && (rd_s3 != 5'd0)) begin
            load_use_o = hit_rs1 || hit_rs2;
        end
    end

endmodule

// File: rtl/riscv_pipe_ctrl.sv
// Pipeline control for the 5-stage core: stage enables, NOP inserts, PC control,
// data-memory wait/timeout FSM and saturating stall/flush counters.
module riscv_pipe_ctrl
    import riscv_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      inst_s2,
    input  logic [31:0]      inst_s3,
    input  logic [31:0]      inst_s4,
    input  logic             br_taken_s3,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             pc_redirect,
    output logic             en_s12,
    output logic             en_s23,
    output logic             en_s34,
    output logic             en_s45,
    output logic             nop_s12,
    output logic             nop_s23,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int         WCNT_W  = 8;
    localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

    pipe_state_e       state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              mem_err_q, mem_err_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic load_use;
    logic mem_op_s4;
    logic mem_pending;
    logic freeze;
    logic unused_s4;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    riscv_load_use_det u_load_use_det (
        .inst_s2_i  (inst_s2),
        .inst_s3_i  (inst_s3),
        .load_use_o (load_use)
    );

    assign unused_s4   = ^inst_s4[31:7];
    assign mem_op_s4   = is_mem_op(inst_s4[6:0]);
    assign mem_pending = mem_op_s4 && !dmem_ready;
    // The abort cycle releases the stuck access even though dmem is still not ready.
    assign freeze      = mem_pending && (state_q != ST_MEM_ABORT);

    always_comb begin
        pc_en       = 1'b1;
        pc_redirect = 1'b0;
        en_s12      = 1'b1;
        en_s23      = 1'b1;
        en_s34      = 1'b1;
        en_s45      = 1'b1;
        nop_s12     = 1'b0;
        nop_s23     = 1'b0;
        if (rst || freeze) begin
            pc_en  = 1'b0;
            en_s12 = 1'b0;
            en_s23 = 1'b0;
            en_s34 = 1'b0;
            en_s45 = 1'b0;
        end else if (br_taken_s3) begin
            pc_redirect = 1'b1;
            nop_s12     = 1'b1;
            nop_s23     = 1'b1;
        end else if (load_use) begin
            pc_en   = 1'b0;
            en_s12  = 1'b0;
            nop_s23 = 1'b1;
        end else if (!imem_ready) begin
            pc_en   = 1'b0;
            nop_s12 = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        mem_err_d = mem_err_q;
        unique case (state_q)
            ST_RUN: begin
                if (mem_pending) begin
                    state_d = ST_MEM_WAIT;
                    wcnt_d  = 8'd1;
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_ready) begin
                    state_d = ST_RUN;
                    wcnt_d  = '0;
                end else if (wcnt_q == TO_LAST) begin
                    state_d   = ST_MEM_ABORT;
                    wcnt_d    = '0;
                    mem_err_d = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end
            ST_MEM_ABORT: begin
                state_d = ST_RUN;
                wcnt_d  = '0;
            end
            default: begin
                state_d = ST_RUN;
                wcnt_d  = '0;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = pc_en ? stall_cnt_q : sat_inc(stall_cnt_q);
        flush_cnt_d = pc_redirect ? sat_inc(flush_cnt_q) : flush_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            wcnt_q      <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_riscv_pipe_ctrl.sv
// Scoreboard bench for riscv_pipe_ctrl: directed hazard scenarios plus random traffic
// against a rule-level reference model; a negedge monitor pops and compares.
module tb_riscv_pipe_ctrl;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 4;
    localparam int MAXC        = (1 << CNT_W) - 1;

    localparam logic [6:0] O_LOAD = 7'b0000011, O_STORE = 7'b0100011, O_R = 7'b0110011,
                           O_I = 7'b0010011, O_BR = 7'b1100011, O_JALR = 7'b1100111,
                           O_JAL = 7'b1101111, O_LUI = 7'b0110111;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [31:0]      inst_s2 = NOP, inst_s3 = NOP, inst_s4 = NOP;
    logic             br_taken_s3 = 1'b0, imem_ready = 1'b1, dmem_ready = 1'b1;
    logic             pc_en, pc_redirect, en_s12, en_s23, en_s34, en_s45;
    logic             nop_s12, nop_s23, mem_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    riscv_pipe_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .inst_s2(inst_s2), .inst_s3(inst_s3), .inst_s4(inst_s4),
        .br_taken_s3(br_taken_s3), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .pc_redirect(pc_redirect), .en_s12(en_s12), .en_s23(en_s23),
        .en_s34(en_s34), .en_s45(en_s45), .nop_s12(nop_s12), .nop_s23(nop_s23),
        .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0]       ctl;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fc;
        int               cyc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    // Reference model state: consecutive frozen cycles, abort-release pending, sticky error.
    int m_frozen = 0;
    bit m_abort = 0;
    bit m_err = 0;
    int m_stall = 0;
    int m_flush = 0;

    function automatic logic [31:0] enc_r(input logic [4:0] rd, rs1, rs2);
        return {7'd0, rs2, rs1, 3'd0, rd, O_R};
    endfunction
    function automatic logic [31:0] enc_i(input logic [6:0] opc, input logic [4:0] rd, rs1,
                                          input logic [11:0] imm);
        return {imm, rs1, 3'd0, rd, opc};
    endfunction
    function automatic logic [31:0] enc_s(input logic [4:0] rs1, rs2);
        return {7'd0, rs2, rs1, 3'b010, 5'd0, O_STORE};
    endfunction

    function automatic bit m_load_use(input logic [31:0] s2, input logic [31:0] s3);
        logic [6:0] o2;
        logic [4:0] rd3;
        bit r1, r2;
        o2  = s2[6:0];
        rd3 = s3[11:7];
        r1  = o2 inside {O_R, O_I, O_LOAD, O_STORE, O_BR, O_JALR};
        r2  = o2 inside {O_R, O_STORE, O_BR};
        return (s3[6:0] == O_LOAD) && (rd3 != 5'd0) &&
               ((r1 && s2[19:15] == rd3) || (r2 && s2[24:20] == rd3));
    endfunction

    function automatic logic [31:0] rnd_inst();
        logic [31:0] r;
        logic [6:0]  opc;
        r = $urandom;
        case ($urandom_range(0, 7))
            0: opc = O_LOAD;  1: opc = O_STORE; 2: opc = O_R;   3: opc = O_I;
            4: opc = O_BR;    5: opc = O_JALR;  6: opc = O_JAL; default: opc = O_LUI;
        endcase
        r[6:0]   = opc;
        r[11:7]  = 5'($urandom_range(0, 3));
        r[19:15] = 5'($urandom_range(0, 3));
        r[24:20] = 5'($urandom_range(0, 3));
        return r;
    endfunction

    task automatic step(input logic [31:0] s2, s3, s4, input bit br, ir, dr, r);
        exp_t e;
        bit pe, rd, e12, e23, e34, e45, n12, n23, frz;
        @(posedge clk);
        #1;
        rst = r; inst_s2 = s2; inst_s3 = s3; inst_s4 = s4;
        br_taken_s3 = br; imem_ready = ir; dmem_ready = dr;
        cyc++;
        pe = 1; rd = 0; e12 = 1; e23 = 1; e34 = 1; e45 = 1; n12 = 0; n23 = 0;
        if (r) begin
            m_frozen = 0; m_abort = 0; m_err = 0; m_stall = 0; m_flush = 0;
            pe = 0; e12 = 0; e23 = 0; e34 = 0; e45 = 0;
            frz = 0;
        end else begin
            frz = (s4[6:0] == O_LOAD || s4[6:0] == O_STORE) && !dr && !m_abort;
            if (frz) begin
                pe = 0; e12 = 0; e23 = 0; e34 = 0; e45 = 0;
            end else if (br) begin
                rd = 1; n12 = 1; n23 = 1;
            end else if (m_load_use(s2, s3)) begin
                pe = 0; e12 = 0; n23 = 1;
            end else if (!ir) begin
                pe = 0; n12 = 1;
            end
        end
        e.ctl = {pe, rd, e12, e23, e34, e45, n12, n23, m_err};
        e.sc  = CNT_W'(m_stall);
        e.fc  = CNT_W'(m_flush);
        e.cyc = cyc;
        q.push_back(e);
        if (!r) begin
            if (!pe && m_stall < MAXC) m_stall++;
            if (rd && m_flush < MAXC) m_flush++;
            if (m_abort) begin
                m_abort = 0; m_frozen = 0;
            end else if (frz) begin
                m_frozen++;
                if (m_frozen == MEM_TIMEOUT) begin
                    m_abort = 1; m_err = 1; m_frozen = 0;
                end
            end else begin
                m_frozen = 0;
            end
        end
    endtask

    initial begin : monitor
        exp_t e;
        logic [8:0] act;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e   = q.pop_front();
                act = {pc_en, pc_redirect, en_s12, en_s23, en_s34, en_s45, nop_s12, nop_s23, mem_err};
                checks++;
                if (act !== e.ctl) begin
                    errors++;
                    $display("FAIL ctl cyc=%0d got=%b exp=%b (pc_en,redir,en12,en23,en34,en45,nop12,nop23,mem_err)",
                             e.cyc, act, e.ctl);
                end
                checks++;
                if (stall_cnt !== e.sc || flush_cnt !== e.fc) begin
                    errors++;
                    $display("FAIL cnt cyc=%0d got stall=%0d flush=%0d exp stall=%0d flush=%0d",
                             e.cyc, stall_cnt, flush_cnt, e.sc, e.fc);
                end
            end
        end
    end

    initial begin : driver
        logic [31:0] lw5, add_x5, hold_s4, s4;
        bit rr;
        lw5    = enc_i(O_LOAD, 5'd5, 5'd1, 12'd0);
        add_x5 = enc_r(5'd6, 5'd5, 5'd2);

        // Reset, then one load-use bubble and recovery.
        repeat (2) step(NOP, NOP, NOP, 0, 1, 1, 1);
        step(add_x5, lw5, NOP, 0, 1, 1, 0);
        step(add_x5, NOP, lw5, 0, 1, 1, 0);
        step(NOP, add_x5, NOP, 0, 1, 1, 0);

        // No false stalls: rd=x0 and an unused rs2 field.
        step(enc_r(5'd6, 5'd0, 5'd0), enc_i(O_LOAD, 5'd0, 5'd1, 12'd0), NOP, 0, 1, 1, 0);
        step(enc_i(O_I, 5'd6, 5'd7, 12'd5), lw5, NOP, 0, 1, 1, 0);

        // Redirect while fetch is not ready, also overlapping a load-use.
        step(NOP, NOP, NOP, 1, 0, 1, 0);
        step(add_x5, lw5, NOP, 1, 1, 1, 0);

        // Store waits three cycles then completes.
        repeat (3) step(NOP, NOP, enc_s(5'd1, 5'd2), 1, 1, 0, 0);
        step(NOP, NOP, enc_s(5'd1, 5'd2), 0, 1, 1, 0);
        step(NOP, NOP, NOP, 0, 1, 1, 0);

        // Timeout: four frozen cycles, one release, sticky error.
        repeat (5) step(NOP, NOP, lw5, 0, 1, 0, 0);
        repeat (3) step(NOP, NOP, NOP, 0, 1, 1, 0);

        // Reset in the middle of a wait.
        repeat (2) step(NOP, NOP, lw5, 0, 1, 0, 0);
        step(NOP, NOP, lw5, 0, 1, 0, 1);
        step(NOP, NOP, NOP, 0, 1, 1, 0);

        // Counter saturation via fetch stalls.
        repeat (20) step(NOP, NOP, NOP, 0, 0, 1, 0);
        repeat (20) step(NOP, NOP, NOP, 1, 1, 1, 0);
        step(NOP, NOP, NOP, 0, 1, 1, 1);

        // Random traffic; a waiting MEM access holds its instruction like a frozen pipe would.
        hold_s4 = NOP;
        for (int i = 0; i < 1500; i++) begin
            s4 = (m_frozen > 0) ? hold_s4 : rnd_inst();
            hold_s4 = s4;
            rr = ($urandom_range(0, 199) == 0);
            step(rnd_inst(), rnd_inst(), s4, ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), rr);
        end

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending expected=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/riscv_pipe_ctrl.md
# riscv_pipe_ctrl

Pipeline control unit for the 5-stage RISC-V core. Sits beside the forwarding unit and owns every pipeline-register enable and NOP-insert. It resolves four hazards: load-use stalls that forwarding cannot cover, branch/jump redirect flushes, instruction-fetch wait, and data-memory wait with timeout. It also keeps saturating stall and flush performance counters.

## Interface
- MEM_TIMEOUT, 16: maximum consecutive MEM_WAIT cycles before abort; range 2..255.
- CNT_W, 16: width of the performance counters.

- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- inst_s2  in  32  instruction in ID.
- inst_s3  in  32  instruction in EX.
- inst_s4  in  32  instruction in MEM.
- br_taken_s3  in  1  EX-stage branch taken, or JAL/JALR resolved.
- imem_ready  in  1  fetch data valid this cycle.
- dmem_ready  in  1  data access in MEM completes this cycle.
- pc_en  out  1  PC register load enable.
- pc_redirect  out  1  PC takes the EX target instead of PC+4.
- en_s12, en_s23, en_s34, en_s45  out  1 each  pipeline-register load enables.
- nop_s12, nop_s23  out  1 each  load NOP (0x00000013) into IF/ID and ID/EX respectively.
- mem_err  out  1  sticky flag, set on dmem timeout.
- stall_cnt  out  CNT_W  count of cycles with pc_en=0 outside reset; saturating.
- flush_cnt  out  CNT_W  count of redirects; saturating.

## Operation
- Opcodes used: LOAD 0000011, STORE 0100011, R 0110011, I 0010011, BRANCH 1100011, JALR 1100111.
- Register-use rules:
  - rs1 users: R, I, LOAD, STORE, BRANCH, JALR.
  - rs2 users: R, STORE, BRANCH.
- load_use: inst_s3 is LOAD, rd(s3) != 0, and rd(s3) equals a source that inst_s2 actually uses.
- Load-to-use from s4 is handled by forwarding, not by this block.
- mem_op_s4: inst_s4 is LOAD or STORE.
- FSM states: RUN, MEM_WAIT, MEM_ABORT.
  - RUN: mem_op_s4 & !dmem_ready goes to MEM_WAIT, wait counter = 1.
  - MEM_WAIT: dmem_ready goes to RUN.
  - MEM_WAIT: counter == MEM_TIMEOUT-1 & !dmem_ready goes to MEM_ABORT and sets mem_err. Otherwise the counter increments.
  - MEM_ABORT: unconditionally goes to RUN after one cycle. The stalled access is released as complete; the data is undefined.
- Per-cycle action, highest priority first:
  1. Freeze: when mem_op_s4 & !dmem_ready and state != MEM_ABORT, all enables and pc_en are 0 and all nop_* are 0.
  2. Redirect: when br_taken_s3, pc_en=1, pc_redirect=1, all enables=1, nop_s12=1, nop_s23=1. This holds regardless of imem_ready, so the target fetch is not blocked.
  3. Load-use: pc_en=0, en_s12=0, en_s23=1, nop_s23=1, en_s34=en_s45=1.
  4. Fetch wait (!imem_ready): pc_en=0, en_s12=1, nop_s12=1, downstream enables=1.
  5. Run: pc_en and all enables=1, nop_*=0, pc_redirect=0.
- Control outputs are combinational from the inputs and the FSM state. Counters, the FSM and mem_err are registered.
- Counters:
  - stall_cnt increments on every cycle with pc_en=0.
  - flush_cnt increments on every redirect cycle.
  - Both hold at all-ones once reached.

## Timing
- Reset (asynchronous, takes effect immediately):
  - State RUN, wait counter 0, mem_err=0, stall_cnt=0, flush_cnt=0.
  - While rst=1, the combinational outputs are forced: pc_en=0, all en_*=0, nop_*=0, pc_redirect=0.
- Load-use costs exactly one bubble. The next cycle, s3 holds the NOP, so the condition clears without extra state.
- Redirect squashes two instructions (IF/ID and ID/EX) in the same cycle, with zero added latency.
- MEM_WAIT freeze holds for N cycles, where N is the number of cycles dmem_ready is low.
  - If N ≥ MEM_TIMEOUT, the freeze lasts MEM_TIMEOUT cycles, then one release cycle in MEM_ABORT.
- Simultaneous events:
  - freeze + branch: freeze wins; the branch is re-evaluated after the release.
  - branch + load_use: redirect wins (the s2 instruction is squashed anyway).
- Reset mid-MEM_WAIT: state, counter and outputs clear immediately; mem_err is not set.

## Structure
- Shared package riscv_pkg holds:
  - opcode constants;
  - the NOP encoding 0x00000013;
  - FSM state encodings (2 bits);
  - rs1/rs2-usage decode functions, shared with the forwarding unit.
- One sub-module, riscv_load_use_det, holds the purely combinational load_use compare. The top level holds the FSM, the priority mux and the counters.

## Test plan
- Load-use: s3 = lw x5,0(x1); s2 = add x6,x5,x2; imem/dmem ready. Required: one cycle with pc_en=0, en_s12=0, nop_s23=1, then run; stall_cnt=1.
- No false stall: s3 = lw x0; s2 uses x0. Required: no stall. Repeat with s2 = addi x6,x7,5 and s3 rd = x5, where rs2 field = 5 but is unused. Required: no stall.
- Redirect: br_taken_s3=1 with imem_ready=0. Required: pc_redirect=1, pc_en=1, nop_s12=nop_s23=1; flush_cnt=1.
- Memory wait: s4 = sw, dmem_ready low for 3 cycles. Required: all enables 0 for 3 cycles, release on the 4th; mem_err=0.
- Timeout with MEM_TIMEOUT=4: dmem_ready held low. Required: 4 frozen cycles, one MEM_ABORT release cycle, mem_err=1 and sticky. Assert rst mid-wait in a second run. Required: immediate return to RUN, counters 0.
- Saturation with CNT_W=4: force 20 stall cycles. Required: stall_cnt holds at 15.
